// File: rtl/max_pool_3d_stream.sv
// Streams a 2x2 / stride-2 signed max pool of a live-indexed 3-D tensor,
// one pooled word per beat, channel-major then row-major, on a valid/ready port.
module max_pool_3d_stream #(
  parameter int BUS_WIDTH = 32,
  parameter int DEPTH     = 8,
  parameter int HEIGHT    = 8,
  parameter int WIDTH     = 8
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  start,
  input  logic [DEPTH-1:0][HEIGHT-1:0][WIDTH-1:0][BUS_WIDTH-1:0] signal_in,
  output logic                                                  busy,
  output logic signed [BUS_WIDTH-1:0]                           out_data,
  output logic                                                  out_valid,
  input  logic                                                  out_ready,
  output logic                                                  out_last,
  output logic                                                  done
);
  localparam int OH = HEIGHT / 2;
  localparam int OW = WIDTH / 2;
  localparam int DW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = (OH > 1) ? $clog2(OH) : 1;
  localparam int CW = (OW > 1) ? $clog2(OW) : 1;
  localparam int HW = $clog2(HEIGHT);
  localparam int WW = $clog2(WIDTH);
  localparam bit SINGLE = (DEPTH * OH * OW == 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic signed [BUS_WIDTH-1:0] elem_t;

  state_t        state, state_n;
  logic [DW-1:0] d, d_n, nd, pd;
  logic [RW-1:0] r, r_n, nr, pr;
  logic [CW-1:0] c, c_n, nc, pc;
  elem_t         data_n, pooled;
  logic          valid_n, last_n, xfer;

  function automatic elem_t smax(input elem_t a, input elem_t b);
    return (a > b) ? a : b;
  endfunction

  // Window corners: odd trailing row/col never addressed since 2*OH <= HEIGHT.
  always_comb begin
    pooled = smax(smax($signed(signal_in[pd][HW'({pr, 1'b0})][WW'({pc, 1'b0})]),
                       $signed(signal_in[pd][HW'({pr, 1'b0})][WW'({pc, 1'b1})])),
                  smax($signed(signal_in[pd][HW'({pr, 1'b1})][WW'({pc, 1'b0})]),
                       $signed(signal_in[pd][HW'({pr, 1'b1})][WW'({pc, 1'b1})])));
  end

  // Counter successor, c fastest, then r, then d.
  always_comb begin
    nc = c + 1'b1;
    nr = r;
    nd = d;
    if (c == CW'(OW - 1)) begin
      nc = '0;
      if (r == RW'(OH - 1)) begin
        nr = '0;
        nd = d + 1'b1;
      end else begin
        nr = r + 1'b1;
      end
    end
  end

  assign xfer = out_valid & out_ready;

  always_comb begin
    state_n = state;
    d_n     = d;
    r_n     = r;
    c_n     = c;
    data_n  = out_data;
    valid_n = out_valid;
    last_n  = out_last;
    pd      = nd;
    pr      = nr;
    pc      = nc;
    case (state)
      IDLE: begin
        pd = '0;
        pr = '0;
        pc = '0;
        if (start) begin
          state_n = RUN;
          d_n     = '0;
          r_n     = '0;
          c_n     = '0;
          data_n  = pooled;
          valid_n = 1'b1;
          last_n  = SINGLE;
        end
      end
      RUN: begin
        if (xfer) begin
          if (out_last) begin
            state_n = DONE;
            valid_n = 1'b0;
            last_n  = 1'b0;
          end else begin
            d_n    = nd;
            r_n    = nr;
            c_n    = nc;
            data_n = pooled;
            last_n = (nd == DW'(DEPTH - 1)) && (nr == RW'(OH - 1)) && (nc == CW'(OW - 1));
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      d         <= '0;
      r         <= '0;
      c         <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_n;
      d         <= d_n;
      r         <= r_n;
      c         <= c_n;
      out_data  <= data_n;
      out_valid <= valid_n;
      out_last  <= last_n;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
endmodule
